// File: rtl/pmem_arb_pkg.sv
// Shared constants, FSM state type and address helper for the line arbiter.
// Line/beat geometry is fixed here so the interface, arbiter and bench agree.
package pmem_arb_pkg;

    localparam int CACHE_LINE_WIDTH = 256;
    localparam int BURST_LEN        = 4;
    localparam int ADDR_WIDTH       = 32;

    localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
    localparam int OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int CNT_WIDTH   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_DONE     = 2'd3
    } pmem_arb_state_t;

    // Clears the byte-within-line offset so memory always sees line-aligned addresses.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/pmem_line_arbiter_if.sv
// Bundle of the two cache-line requester ports, the burst memory port and the error flag.
// The arbiter connects through the slave modport; the environment uses master.
interface pmem_line_arbiter_if;
    import pmem_arb_pkg::*;

    // Handshake: a requester holds read/write/addr/wdata until its one-cycle resp
    // pulse (rdata valid with resp) and drops the request the cycle after.
    // Memory holds mem_read/mem_write/mem_addr steady until the last beat; each
    // cycle with mem_resp=1 transfers one beat, BURST_LEN beats per command.
    logic                        req0_read;
    logic                        req0_write;
    logic [ADDR_WIDTH-1:0]       req0_addr;
    logic [CACHE_LINE_WIDTH-1:0] req0_wdata;
    logic [CACHE_LINE_WIDTH-1:0] req0_rdata;
    logic                        req0_resp;

    logic                        req1_read;
    logic                        req1_write;
    logic [ADDR_WIDTH-1:0]       req1_addr;
    logic [CACHE_LINE_WIDTH-1:0] req1_wdata;
    logic [CACHE_LINE_WIDTH-1:0] req1_rdata;
    logic                        req1_resp;

    logic                        mem_read;
    logic                        mem_write;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [BURST_WIDTH-1:0]      mem_wdata;
    logic [BURST_WIDTH-1:0]      mem_rdata;
    logic                        mem_resp;
    logic                        mem_error;

    logic                        err_sticky;

    modport slave (
        input  req0_read, req0_write, req0_addr, req0_wdata,
        output req0_rdata, req0_resp,
        input  req1_read, req1_write, req1_addr, req1_wdata,
        output req1_rdata, req1_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp, mem_error,
        output err_sticky
    );

    modport master (
        output req0_read, req0_write, req0_addr, req0_wdata,
        input  req0_rdata, req0_resp,
        output req1_read, req1_write, req1_addr, req1_wdata,
        input  req1_rdata, req1_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp, mem_error,
        input  err_sticky
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the port that
// did not win last time is chosen.
module rr_arb2 (
    input  logic i_pend0,
    input  logic i_pend1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_id
);

    always_comb begin
        o_grant_valid = i_pend0 | i_pend1;
        o_grant_id    = 1'b0;
        if (i_pend0 && i_pend1) begin
            o_grant_id = ~i_last_grant;
        end else if (i_pend1) begin
            o_grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/pmem_line_arbiter.sv
// Shares one burst memory port between the I-cache (port 0) and D-cache (port 1),
// splitting line writes into beats and assembling read beats into a line.
module pmem_line_arbiter
    import pmem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pmem_line_arbiter_if.slave bus,
    output pmem_arb_state_t    o_dbg_state
);

    pmem_arb_state_t             r_state;
    logic                        r_port;
    logic                        r_last_grant;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CACHE_LINE_WIDTH-1:0] r_buf;
    logic                        r_mem_read;
    logic                        r_mem_write;
    logic [ADDR_WIDTH-1:0]       r_mem_addr;
    logic                        r_resp0;
    logic                        r_resp1;
    logic                        r_err;

    logic                        w_pend0;
    logic                        w_pend1;
    logic                        w_grant_valid;
    logic                        w_grant_id;
    logic                        w_sel_read;
    logic                        w_sel_write;
    logic [ADDR_WIDTH-1:0]       w_sel_addr;
    logic [CACHE_LINE_WIDTH-1:0] w_sel_wdata;
    logic                        w_last_beat;
    logic [BURST_WIDTH-1:0]      w_beat_wdata;

    assign w_pend0 = bus.req0_read | bus.req0_write;
    assign w_pend1 = bus.req1_read | bus.req1_write;

    rr_arb2 u_rr_arb2 (
        .i_pend0       (w_pend0),
        .i_pend1       (w_pend1),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_comb begin
        w_sel_read  = bus.req0_read;
        w_sel_write = bus.req0_write;
        w_sel_addr  = bus.req0_addr;
        w_sel_wdata = bus.req0_wdata;
        if (w_grant_id) begin
            w_sel_read  = bus.req1_read;
            w_sel_write = bus.req1_write;
            w_sel_addr  = bus.req1_addr;
            w_sel_wdata = bus.req1_wdata;
        end
    end

    // The counter never passes BURST_LEN-1: the terminal beat ends the burst instead.
    assign w_last_beat  = (r_cnt == CNT_WIDTH'(BURST_LEN - 1));
    assign w_beat_wdata = r_buf[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_port       <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_resp0      <= 1'b0;
            r_resp1      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_port       <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_mem_addr   <= line_align(w_sel_addr);
                        r_buf        <= w_sel_wdata;
                        r_cnt        <= '0;
                        // Read+write together is illegal; the write wins so no data is lost.
                        if (w_sel_write) begin
                            r_mem_write <= 1'b1;
                            r_state     <= ST_WR_BURST;
                            if (w_sel_read) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= ST_RD_BURST;
                        end
                    end
                end

                ST_RD_BURST: begin
                    if (bus.mem_error) begin
                        r_err      <= 1'b1;
                        r_mem_read <= 1'b0;
                        r_resp0    <= ~r_port;
                        r_resp1    <= r_port;
                        r_state    <= ST_DONE;
                    end else if (bus.mem_resp) begin
                        r_buf[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH] <= bus.mem_rdata;
                        if (w_last_beat) begin
                            r_mem_read <= 1'b0;
                            r_resp0    <= ~r_port;
                            r_resp1    <= r_port;
                            r_state    <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_WR_BURST: begin
                    if (bus.mem_error) begin
                        r_err       <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_resp0     <= ~r_port;
                        r_resp1     <= r_port;
                        r_state     <= ST_DONE;
                    end else if (bus.mem_resp) begin
                        if (w_last_beat) begin
                            r_mem_write <= 1'b0;
                            r_resp0     <= ~r_port;
                            r_resp1     <= r_port;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_resp0 <= 1'b0;
                    r_resp1 <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_resp  = r_resp0;
    assign bus.req1_resp  = r_resp1;
    assign bus.req0_rdata = r_resp0 ? r_buf : '0;
    assign bus.req1_rdata = r_resp1 ? r_buf : '0;

    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = (r_state == ST_WR_BURST) ? w_beat_wdata : '0;

    assign bus.err_sticky = r_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for the line arbiter: the initial block plays both caches and
// the burst memory, with every expected value written out by hand.
module tb_pmem_line_arbiter;
    import pmem_arb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    pmem_arb_state_t dbg_state;
    int              n_assert = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    pmem_line_arbiter_if bus ();

    pmem_line_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_read  = 1'b0;
        bus.req0_write = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_wdata = '0;
        bus.req1_read  = 1'b0;
        bus.req1_write = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
        bus.mem_error  = 1'b0;
    endtask

    task automatic wait_cmd(input string tag);
        int waited = 0;
        while (!(bus.mem_read || bus.mem_write) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_cmd_seen"}, 256'(bus.mem_read | bus.mem_write), 256'd1);
    endtask

    // Plays the memory for one full transfer and checks the outcome at the DONE cycle.
    task automatic serve(input string tag, input bit exp_wr, input logic [31:0] exp_addr,
                         input int delay, input logic [255:0] rline,
                         input logic [255:0] wline, input bit exp_port);
        bit           steady = 1'b1;
        logic [1:0]   kind;
        logic [255:0] cap = '0;
        kind = exp_wr ? 2'b10 : 2'b01;
        wait_cmd(tag);
        chk({tag, "_cmd_kind"}, 256'({bus.mem_write, bus.mem_read}), 256'(kind));
        chk({tag, "_mem_addr"}, 256'(bus.mem_addr), 256'(exp_addr));
        repeat (delay) begin
            @(negedge clk);
            if (bus.mem_addr !== exp_addr || {bus.mem_write, bus.mem_read} !== kind) steady = 1'b0;
        end
        for (int b = 0; b < BURST_LEN; b++) begin
            if (bus.mem_addr !== exp_addr || {bus.mem_write, bus.mem_read} !== kind) steady = 1'b0;
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = rline[b*BURST_WIDTH +: BURST_WIDTH];
            cap[b*BURST_WIDTH +: BURST_WIDTH] = bus.mem_wdata;
            @(negedge clk);
        end
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        chk({tag, "_cmd_steady"}, 256'(steady), 256'd1);
        chk({tag, "_cmd_drop"}, 256'({bus.mem_write, bus.mem_read}), 256'd0);
        chk({tag, "_resp"}, 256'({bus.req1_resp, bus.req0_resp}), exp_port ? 256'd2 : 256'd1);
        if (exp_wr) begin
            chk({tag, "_wbeats"}, cap, wline);
        end else begin
            chk({tag, "_rdata"}, exp_port ? bus.req1_rdata : bus.req0_rdata, rline);
        end
    endtask

    task automatic idle_resp_check(input string tag);
        @(negedge clk);
        chk({tag, "_resp_pulse"}, 256'({bus.req1_resp, bus.req0_resp}), 256'd0);
    endtask

    initial begin
        logic [255:0] line;
        int           served0;
        int           served1;
        bit           exp_p;

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd", 256'({bus.mem_write, bus.mem_read}), 256'd0);
        chk("rst_addr", 256'(bus.mem_addr), 256'd0);
        chk("rst_resp", 256'({bus.req1_resp, bus.req0_resp}), 256'd0);
        chk("rst_err", 256'(bus.err_sticky), 256'd0);
        chk("rst_state", 256'(dbg_state), 256'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: port 0 line read with 10-cycle memory latency
        bus.req0_read = 1'b1;
        bus.req0_addr = 32'h0000_1044;
        serve("t1", 1'b0, 32'h0000_1040, 10, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, '0, 1'b0);
        bus.req0_read = 1'b0;
        idle_resp_check("t1");

        // 2: port 1 line write, beats must leave in order D0..D3
        line = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        bus.req1_write = 1'b1;
        bus.req1_addr  = 32'h0000_0200;
        bus.req1_wdata = line;
        serve("t2", 1'b1, 32'h0000_0200, 0, '0, line, 1'b1);
        bus.req1_write = 1'b0;
        idle_resp_check("t2");

        // 3: both ports keep requesting reads; grants must alternate 0,1,0,1,0,1
        bus.req0_read = 1'b1;
        bus.req0_addr = 32'h0000_3000;
        bus.req1_read = 1'b1;
        bus.req1_addr = 32'h0000_4000;
        served0 = 0;
        served1 = 0;
        for (int i = 0; i < 6; i++) begin
            exp_p = (i % 2) == 1;
            line  = {4{64'(i + 1)}} ^ {64'h3, 64'h2, 64'h1, 64'h0};
            serve($sformatf("t3_%0d", i), 1'b0, exp_p ? 32'h0000_4000 : 32'h0000_3000, 2, line, '0, exp_p);
            if (exp_p) begin
                bus.req1_read = 1'b0;
                served1++;
            end else begin
                bus.req0_read = 1'b0;
                served0++;
            end
            idle_resp_check($sformatf("t3_%0d", i));
            if (!exp_p && served0 < 3) bus.req0_read = 1'b1;
            if (exp_p && served1 < 3) bus.req1_read = 1'b1;
        end

        // 4: reset lands while beat 2 of a port 0 write is on the bus
        bus.req0_write = 1'b1;
        bus.req0_addr  = 32'h0000_0500;
        bus.req0_wdata = {4{64'h5555_0000_AAAA_0000}};
        wait_cmd("t4");
        for (int b = 0; b < 2; b++) begin
            bus.mem_resp = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("t4_cmd", 256'({bus.mem_write, bus.mem_read}), 256'd0);
        chk("t4_addr", 256'(bus.mem_addr), 256'd0);
        chk("t4_wdata", 256'(bus.mem_wdata), 256'd0);
        chk("t4_resp", 256'({bus.req1_resp, bus.req0_resp}), 256'd0);
        chk("t4_state", 256'(dbg_state), 256'(ST_IDLE));
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req0_read = 1'b1;
        bus.req0_addr = 32'h0000_9000;
        bus.req1_read = 1'b1;
        bus.req1_addr = 32'h0000_A000;
        serve("t4_tie0", 1'b0, 32'h0000_9000, 1, {4{64'h9}}, '0, 1'b0);
        bus.req0_read = 1'b0;
        idle_resp_check("t4_tie0");
        serve("t4_tie1", 1'b0, 32'h0000_A000, 1, {4{64'hA}}, '0, 1'b1);
        bus.req1_read = 1'b0;
        idle_resp_check("t4_tie1");

        // 5: memory error mid read releases the requester and sets the sticky flag
        bus.req1_read = 1'b1;
        bus.req1_addr = 32'h0000_B000;
        wait_cmd("t5");
        chk("t5_err_before", 256'(bus.err_sticky), 256'd0);
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_error = 1'b1;
        @(negedge clk);
        bus.mem_error = 1'b0;
        chk("t5_err_set", 256'(bus.err_sticky), 256'd1);
        chk("t5_resp", 256'({bus.req1_resp, bus.req0_resp}), 256'd2);
        chk("t5_cmd_drop", 256'({bus.mem_write, bus.mem_read}), 256'd0);
        bus.req1_read = 1'b0;
        @(negedge clk);
        chk("t5_state_idle", 256'(dbg_state), 256'(ST_IDLE));
        bus.req0_read = 1'b1;
        bus.req0_addr = 32'h0000_C000;
        serve("t5_next", 1'b0, 32'h0000_C000, 1, {4{64'hC}}, '0, 1'b0);
        bus.req0_read = 1'b0;
        idle_resp_check("t5_next");
        chk("t5_err_held", 256'(bus.err_sticky), 256'd1);

        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_err_clr", 256'(bus.err_sticky), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: read and write together on port 0 is served as a write and flagged
        line = {64'h6003, 64'h6002, 64'h6001, 64'h6000};
        bus.req0_read  = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 32'h0000_D010;
        bus.req0_wdata = line;
        serve("t6", 1'b1, 32'h0000_D000, 1, '0, line, 1'b0);
        bus.req0_read  = 1'b0;
        bus.req0_write = 1'b0;
        chk("t6_err", 256'(bus.err_sticky), 256'd1);
        idle_resp_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_line_arbiter.md
Name: pmem_line_arbiter

Overview:
- Shares one burst-oriented physical memory port between two cache-line requesters: port 0 is the I-cache, port 1 is the D-cache.
- Arbitrates requests round-robin.
- Serialises each full-line write into BURST_LEN beats and reassembles each read burst into a full line.
- Sits between the L1 caches and the physical memory model / DRAM controller.

Parameters:
- CACHE_LINE_WIDTH, 256, line width in bits.
- BURST_LEN, 4, beats per line transfer. Beat width is BURST_WIDTH = CACHE_LINE_WIDTH/BURST_LEN.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_read / req0_write  in  1 each  port 0 line read / write request; held until req0_resp.
- req0_addr  in  ADDR_WIDTH  port 0 byte address.
- req0_wdata  in  CACHE_LINE_WIDTH  port 0 write line.
- req0_rdata  out  CACHE_LINE_WIDTH  port 0 read line; valid with req0_resp.
- req0_resp  out  1  one-cycle completion pulse for port 0.
- req1_read, req1_write, req1_addr, req1_wdata, req1_rdata, req1_resp: same as port 0, for port 1.
- mem_read / mem_write  out  1 each  memory read / write command.
- mem_addr  out  ADDR_WIDTH  line-aligned memory address.
- mem_wdata  out  BURST_WIDTH  current write beat.
- mem_rdata  in  BURST_WIDTH  read beat; valid when mem_resp=1.
- mem_resp  in  1  per-beat handshake; high for BURST_LEN consecutive cycles per transfer.
- mem_error  in  1  protocol error flagged by memory.
- err_sticky  out  1  set on mem_error or an illegal request; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0; beat counter, line buffer and FSM go to IDLE.
  - last_grant = 1, so port 0 wins the first tie.
  - Reset mid-burst drops mem_read/mem_write immediately.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Pending request means read|write.
  - If exactly one port is pending, grant it. If both are pending, grant the port != last_grant.
  - On grant: latch port id, address and wdata into the line buffer; set last_grant; cnt=0.
  - Go to WR_BURST if write, else RD_BURST. Read and write both high on one port: treat as write and set err_sticky.
- Command outputs are registered and asserted from the first cycle of RD_BURST/WR_BURST.
  - mem_addr = latched addr with the low log2(CACHE_LINE_WIDTH/8) bits zeroed.
  - mem_read/mem_write and mem_addr stay constant until the last beat is accepted.
- RD_BURST:
  - Each cycle with mem_resp=1: buffer[cnt*BURST_WIDTH +: BURST_WIDTH] <= mem_rdata; cnt++.
  - On the edge accepting beat BURST_LEN-1: mem_read <= 0, go to DONE.
- WR_BURST:
  - mem_wdata = buffer slice [cnt] (combinational from the counter).
  - cnt++ on each cycle with mem_resp=1.
  - On the edge accepting the last beat: mem_write <= 0, go to DONE.
- Latency is unbounded while waiting for the first mem_resp; no timeout.
- DONE (exactly one cycle):
  - reqN_resp=1 for the granted port only; reqN_rdata = buffer (reads; don't-care for writes).
  - Next state is IDLE, which re-arbitrates. Requesters drop their request in the cycle after resp.
- Minimum gap between memory commands: 2 cycles (DONE + IDLE).
- mem_error in either burst state: set err_sticky, drop the mem command, go to DONE so the requester is released. Data is undefined.
- Counter width is $clog2(BURST_LEN), with a terminal compare against BURST_LEN-1 and no wrap beyond it.
- mem_resp in IDLE/DONE is ignored.
- Requests arriving during a burst wait; they are never dropped.

Decomposition:
- Package pmem_arb_pkg holds:
  - the state enum pmem_arb_state_t;
  - BURST_WIDTH and OFFSET_BITS derivations;
  - a line_align(addr) function.
- Sub-module rr_arb2 is natural: combinational 2-way round-robin grant from (pend0, pend1, last_grant), producing grant_valid and grant_id.
- Top-level FSM, counter and line buffer live in pmem_line_arbiter.

Test Plan:
1. Port 0 reads 0x0000_1044; memory returns beats 64'hA0..A3 after a 10-cycle delay. Required: mem_addr=0x0000_1040; mem_read steady for all 4 beats; req0_rdata={A3,A2,A1,A0}; req0_resp one cycle; mem_read=0 the cycle after beat 3.
2. Port 1 writes line {D3,D2,D1,D0} to 0x200. Required: mem_wdata equals D0..D3 on successive mem_resp cycles; the memory image at 0x200 matches; req1_resp pulses once; req0_resp stays 0.
3. Both ports request reads in the same cycle, three times back-to-back. Required: grants go 0,1,0,1,0,1 (no starvation), and each resp pulse goes to the correct port.
4. Deassert rst_n during beat 2 of a write. Required: all outputs 0 immediately; after release, the next tie goes to port 0.
5. Pulse mem_error during RD_BURST. Required: err_sticky=1 and stays set; the requester gets resp within 2 cycles; FSM returns to IDLE and serves the next request.
6. Port 0 asserts read and write together. Required: a write burst is issued and err_sticky=1.
